// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the configurable serial pattern match controller.
// Holds the FSM state encoding, the default widths and the pattern length clamp.
package seq_det_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A length of 0 behaves as 1; anything longer than the history behaves as the full history.
    function automatic int clamp_len(input int len, input int pat_w);
        if (len < 1) begin
            return 1;
        end
        if (len > pat_w) begin
            return pat_w;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_shift_cmp.sv
// Serial history shift register with fill counter and length-masked pattern compare.
// hit is evaluated on the post-shift history and fill, so it is only valid on accepted bits.
module seq_shift_cmp
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             clr,
    input  logic             fill_clr,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] mask;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (shift_en) begin
            hist_d = {hist_q[PAT_W-2:0], bit_in};
            if (fill_q < LEN_W'(PAT_W)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign hit = shift_en && (fill_d >= len) && (((hist_d ^ pattern) & mask) == '0);

    // fill_clr restarts the fill count after a non-overlapping match; history is kept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_clr ? '0 : fill_d;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern match controller: config registers, start/abort FSM,
// saturating match counter and held done/ack handshake around seq_shift_cmp.
module seq_match_ctrl
    import seq_det_pkg::*;
#(
    parameter  int PAT_W = PAT_W_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in,
    input  logic             done_ack,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done
);

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q;
    logic             busy_q, match_q, done_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             hit;
    logic             shift_en;
    logic             clr;
    logic             fill_clr;
    logic [LEN_W-1:0] len_eff;

    // Pattern and length come straight from the config registers; a same-edge
    // cfg_we+start is safe because nothing shifts on the start edge.
    assign len_eff  = LEN_W'(clamp_len(int'(len_q), PAT_W));
    assign shift_en = (state_q == ST_RUN) && in_valid && !abort;
    assign clr      = (state_q == ST_IDLE) && start;
    assign fill_clr = hit && !ovl_q;
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    seq_shift_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shift_cmp (
        .clk      (clk),
        .rstn     (rstn),
        .shift_en (shift_en),
        .bit_in   (in),
        .clr      (clr),
        .fill_clr (fill_clr),
        .len      (len_eff),
        .pattern  (pat_q),
        .hit      (hit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            match_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_we) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        ovl_q <= cfg_overlap;
                        tgt_q <= cfg_target;
                    end
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    // Abort wins over a match completing on the same edge.
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (hit) begin
                        match_q <= 1'b1;
                        cnt_q   <= cnt_d;
                        if ((tgt_q != '0) && (cnt_d == tgt_q)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (done_ack || abort) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed self-checking bench for seq_match_ctrl with hand-computed expectations.
module tb_seq_match_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_d;
    logic             done_ack;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;

    int n_pass  = 0;
    int n_total = 0;

    seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in          (in_d),
        .done_ack    (done_ack),
        .busy        (busy),
        .match       (match),
        .match_cnt   (match_cnt),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfg_start(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                             input logic o, input logic [CNT_W-1:0] t);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        start = 1'b1; in_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
    endtask

    task automatic step(input logic v, input logic b, input logic ab, output logic m);
        @(negedge clk);
        in_valid = v; in_d = b; abort = ab;
        @(posedge clk); #1;
        m = match;
        in_valid = 1'b0; abort = 1'b0;
    endtask

    task automatic abort_run();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (match !== 1'b0) $display("FAIL reset_match got %0b want 0", match); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
        n_total++; if (match_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", match_cnt); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_overlap();
        logic [7:0] bits = 8'b1001_0010;
        logic [7:0] exp  = 8'b0000_1001;
        logic m;
        cfg_start(8'b0001_0010, 4'd5, 1'b1, 8'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[7-i], 1'b0, m);
            n_total++;
            if (m !== exp[7-i]) $display("FAIL ovl_match[%0d] got %0b want %0b", i, m, exp[7-i]); else n_pass++;
        end
        n_total++; if (match_cnt !== 8'd2) $display("FAIL ovl_cnt got %0d want 2", match_cnt); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL ovl_busy got %0b want 1", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL ovl_done got %0b want 0", done); else n_pass++;
        abort_run();
        n_total++; if (busy !== 1'b0) $display("FAIL ovl_abort_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (match_cnt !== 8'd2) $display("FAIL ovl_abort_cnt got %0d want 2", match_cnt); else n_pass++;
    endtask

    task automatic test_nonoverlap();
        logic [7:0] bits = 8'b1001_0010;
        logic [7:0] exp  = 8'b0000_1000;
        logic m;
        cfg_start(8'b0001_0010, 4'd5, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[7-i], 1'b0, m);
            n_total++;
            if (m !== exp[7-i]) $display("FAIL novl_match[%0d] got %0b want %0b", i, m, exp[7-i]); else n_pass++;
        end
        n_total++; if (match_cnt !== 8'd1) $display("FAIL novl_cnt got %0d want 1", match_cnt); else n_pass++;
        abort_run();
    endtask

    task automatic test_done_handshake();
        logic [3:0] exp = 4'b0111;
        logic m;
        cfg_start(8'b0000_0011, 4'd2, 1'b1, 8'd3);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, m);
            n_total++;
            if (m !== exp[3-i]) $display("FAIL done_match[%0d] got %0b want %0b", i, m, exp[3-i]); else n_pass++;
        end
        n_total++; if (done !== 1'b1) $display("FAIL done_set got %0b want 1", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL done_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (match_cnt !== 8'd3) $display("FAIL done_cnt got %0d want 3", match_cnt); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, m);
            n_total++;
            if (m !== 1'b0) $display("FAIL done_extra_match[%0d] got %0b want 0", i, m); else n_pass++;
        end
        n_total++; if (match_cnt !== 8'd3) $display("FAIL done_frozen_cnt got %0d want 3", match_cnt); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL done_held got %0b want 1", done); else n_pass++;
        @(negedge clk);
        done_ack = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        done_ack = 1'b0; start = 1'b0;
        n_total++; if (done !== 1'b0) $display("FAIL ack_done got %0b want 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ack_busy got %0b want 0", busy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL ack_start_ignored got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_gaps_abort();
        logic m;
        cfg_start(8'b0000_0101, 4'd3, 1'b1, 8'd0);
        step(1'b1, 1'b1, 1'b0, m);
        step(1'b0, 1'b0, 1'b0, m);
        n_total++; if (m !== 1'b0) $display("FAIL gap_idle0 got %0b want 0", m); else n_pass++;
        step(1'b1, 1'b0, 1'b0, m);
        step(1'b0, 1'b1, 1'b0, m);
        n_total++; if (m !== 1'b0) $display("FAIL gap_idle1 got %0b want 0", m); else n_pass++;
        step(1'b0, 1'b0, 1'b0, m);
        step(1'b1, 1'b1, 1'b0, m);
        n_total++; if (m !== 1'b1) $display("FAIL gap_match got %0b want 1", m); else n_pass++;
        step(1'b1, 1'b0, 1'b0, m);
        n_total++; if (m !== 1'b0) $display("FAIL gap_nomatch got %0b want 0", m); else n_pass++;
        step(1'b1, 1'b1, 1'b1, m);
        n_total++; if (m !== 1'b0) $display("FAIL abort_match got %0b want 0", m); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (match_cnt !== 8'd1) $display("FAIL abort_cnt got %0d want 1", match_cnt); else n_pass++;
    endtask

    task automatic test_illegal_requests();
        logic [3:0]  exp0 = 4'b1011;
        logic [8:0]  exp1 = 9'b0_0000_0011;
        logic m;
        cfg_start(8'b0000_0011, 4'd2, 1'b1, 8'd0);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = 8'b0000_0000; start = 1'b1;
        in_valid = 1'b1; in_d = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0; in_valid = 1'b0;
        step(1'b1, 1'b0, 1'b0, m);
        n_total++; if (m !== 1'b0) $display("FAIL cfg_run_ignored got %0b want 0", m); else n_pass++;
        step(1'b1, 1'b1, 1'b0, m);
        step(1'b1, 1'b1, 1'b0, m);
        n_total++; if (m !== 1'b1) $display("FAIL cfg_run_oldpat got %0b want 1", m); else n_pass++;
        n_total++; if (match_cnt !== 8'd1) $display("FAIL cfg_run_cnt got %0d want 1", match_cnt); else n_pass++;
        abort_run();

        cfg_start(8'b0000_0001, 4'd0, 1'b1, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, exp0[3-i], 1'b0, m);
            n_total++;
            if (m !== exp0[3-i]) $display("FAIL len0_match[%0d] got %0b want %0b", i, m, exp0[3-i]); else n_pass++;
        end
        n_total++; if (match_cnt !== 8'd3) $display("FAIL len0_cnt got %0d want 3", match_cnt); else n_pass++;
        abort_run();

        cfg_start(8'hFF, 4'd15, 1'b1, 8'd0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 1'b0, m);
            n_total++;
            if (m !== exp1[8-i]) $display("FAIL lenmax_match[%0d] got %0b want %0b", i, m, exp1[8-i]); else n_pass++;
        end
        n_total++; if (match_cnt !== 8'd2) $display("FAIL lenmax_cnt got %0d want 2", match_cnt); else n_pass++;
        abort_run();
    endtask

    task automatic test_reset_mid_run();
        logic m;
        cfg_start(8'b0000_0001, 4'd1, 1'b1, 8'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, m);
        end
        n_total++; if (match_cnt !== 8'd5) $display("FAIL pre_rst_cnt got %0d want 5", match_cnt); else n_pass++;
        #2;
        rstn = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (match !== 1'b0) $display("FAIL mid_rst_match got %0b want 0", match); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL mid_rst_done got %0b want 0", done); else n_pass++;
        n_total++; if (match_cnt !== 8'd0) $display("FAIL mid_rst_cnt got %0d want 0", match_cnt); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, 1'b1, 1'b0, m);
        n_total++; if (m !== 1'b0) $display("FAIL post_rst_match got %0b want 0", m); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL post_rst_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (match_cnt !== 8'd0) $display("FAIL post_rst_cnt got %0d want 0", match_cnt); else n_pass++;
        cfg_start(8'b0000_0001, 4'd1, 1'b1, 8'd0);
        n_total++; if (busy !== 1'b1) $display("FAIL restart_busy got %0b want 1", busy); else n_pass++;
        abort_run();
    endtask

    initial begin
        rstn = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_d = 1'b0; done_ack = 1'b0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_done_handshake();
        test_gaps_abort();
        test_illegal_requests();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Programmable serial-pattern match controller.
- Software-style config port loads a pattern of 1..PAT_W bits, a length, an overlap mode and a target match count.
- A start/abort FSM arms the detector, counts matches on a qualified serial bit stream, and raises a held done/ack handshake when the target is reached.
- Replaces the fixed-pattern detectors with one configurable block that sits between the serial front-end and the control/status logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of target and match counter
LEN_W, $clog2(PAT_W)+1, width of the length field (derived; not overridden)

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe; honoured only in IDLE
cfg_pattern  in  PAT_W  pattern; bit [len-1] is the oldest bit, bit [0] the newest
cfg_len  in  LEN_W  pattern length; 0 is treated as 1, values >PAT_W are treated as PAT_W
cfg_overlap  in  1  1=overlapping matches, 0=non-overlapping
cfg_target  in  CNT_W  matches needed for done; 0 = run until abort
start  in  1  arm request
abort  in  1  abort request
in_valid  in  1  serial bit qualifier
in  in  1  serial data bit
done_ack  in  1  clears done
busy  out  1  high in RUN
match  out  1  one-cycle pulse per counted match
match_cnt  out  CNT_W  matches since last start
done  out  1  target reached; held until done_ack

Behaviour:
Reset values:
- state=IDLE; busy, match and done = 0; match_cnt=0.
- history, fill counter and all config registers = 0.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_we latches pattern, len, overlap and target.
  - start -> RUN. Same edge clears history, fill counter and match_cnt.
  - cfg_we and start together: the new config applies to this run.
- RUN:
  - Each in_valid cycle shifts `in` into history (LSB = newest).
  - fill = min(fill+1, PAT_W).
  - Match condition: fill_next >= len AND history_next[len-1:0] == pattern[len-1:0].
  - Cycles with in_valid=0 change nothing.
- Match timing:
  - match pulses on the edge after the accepted bit; latency 1 clk.
  - match_cnt increments on the same edge and saturates at 2^CNT_W-1.
- Overlap mode: history and fill are kept after a match.
- Non-overlap mode: fill is reset to 0 on a match. The next match needs len fresh bits.
- Target reached: if target!=0 and match_cnt_next==target -> DONE, done=1, busy=0, same edge as the final match pulse.
- RUN + abort -> IDLE on that edge.
  - Abort has priority over a simultaneous match: no pulse, no count.
  - match_cnt keeps its last value.
- DONE:
  - Bits are ignored; match_cnt is frozen.
  - done_ack -> IDLE, done=0.
  - start is ignored in DONE, including on the ack cycle.
  - abort in DONE behaves as done_ack.
- Ignored requests:
  - cfg_we outside IDLE is ignored; latched config stays stable for the whole run.
  - start in RUN is ignored.
- Async reset mid-operation returns all state to reset values immediately. No match pulse on the first edge after release.

Decomposition:
- seq_det_pkg:
  - state enum typedef (IDLE, RUN, DONE, 2-bit).
  - PAT_W/CNT_W defaults.
  - len clamp function.
- Sub-module seq_shift_cmp:
  - PAT_W history shift register, fill counter and masked compare.
  - Inputs: shift_en, clr, fill_clr, len, pattern.
  - Output: hit (combinational on next-state values).
- seq_match_ctrl holds the FSM, config registers, counter and handshake.

Test Plan:
- Overlap mode:
  - Config: pattern=5'b10010, len=5, overlap=1, target=0; start.
  - Stream 1,0,0,1,0,0,1,0 (all valid).
  - Expected: match after bits 5 and 8, match_cnt=2, busy=1, done=0.
- Non-overlap mode: same stream with overlap=0 -> single match after bit 5, match_cnt=1.
- Done handshake:
  - pattern=2'b11, len=2, overlap=1, target=3; stream 1,1,1,1.
  - Expected: done=1 and busy=0 on the edge of the third match; match_cnt=3.
  - Extra bits cause no change; done_ack -> IDLE, done=0.
- Gaps and abort:
  - in_valid gaps inserted mid-pattern still match; pulse lands 1 clk after the completing valid bit.
  - abort on the same cycle as the completing bit -> no match, state IDLE, count unchanged.
- Illegal requests:
  - cfg_we during RUN (new pattern) is ignored; matches continue against the old pattern.
  - cfg_len=0 -> acts as len 1, so every 1-bit equal to pattern[0] matches.
- Reset: assert rstn=0 mid-RUN with match_cnt=5 -> all outputs 0 immediately; after release, IDLE and start is required again.
